// File: rtl/adc_spi_scan.sv
// Multi-channel SPI ADC scanner. Addresses the enabled channels of ch_mask in
// round-robin order, one 16-bit command per frame, and reports the pipelined
// result of the previously addressed channel as a tagged one-cycle strobe.
module adc_spi_scan #(
  parameter int NUM_CH   = 2,
  parameter int DATA_W   = 12,
  parameter int CLK_DIV  = 4,
  parameter int CONV_CYC = 80
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              enable,
  input  logic              cont,
  input  logic              start,
  input  logic [NUM_CH-1:0] ch_mask,
  input  logic              ADC_DOUT,
  output logic              ADC_CS_N,
  output logic              ADC_SCLK,
  output logic              ADC_DIN,
  output logic [DATA_W-1:0] sample_data,
  output logic [2:0]        sample_ch,
  output logic              sample_valid,
  output logic              busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SETUP = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_GAP   = 2'd3;

  localparam int CNT_MAX = (CLK_DIV > CONV_CYC) ? CLK_DIV : CONV_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(CONV_CYC - 1);
  localparam logic [4:0]       DATA_BITS = 5'(DATA_W);
  localparam logic [2:0]       LAST_CH   = 3'(NUM_CH - 1);

  // First enabled channel at or after ptr; wraps to the lowest enabled one.
  function automatic logic [2:0] next_enabled(input logic [NUM_CH-1:0] mask,
                                              input logic [2:0]        ptr);
    logic [2:0] hi_ch;
    logic [2:0] lo_ch;
    logic       hi_found;
    hi_ch    = '0;
    lo_ch    = '0;
    hi_found = 1'b0;
    // Descending scan: the last hit written is the lowest qualifying channel.
    for (int j = NUM_CH - 1; j >= 0; j--) begin
      if (mask[j]) begin
        lo_ch = 3'(j);
        if (3'(j) >= ptr) begin
          hi_ch    = 3'(j);
          hi_found = 1'b1;
        end
      end
    end
    return hi_found ? hi_ch : lo_ch;
  endfunction

  function automatic logic [3:0] count_ones(input logic [NUM_CH-1:0] mask);
    logic [3:0] n;
    n = '0;
    for (int j = 0; j < NUM_CH; j++) n = n + 4'(mask[j]);
    return n;
  endfunction

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [3:0]        bit_q, bit_d;
  logic              sclk_q, sclk_d;
  logic              cs_n_q, cs_n_d;
  logic [15:0]       cmd_q, cmd_d;
  logic [DATA_W-1:0] rx_q, rx_d;
  logic [2:0]        cur_ch_q, cur_ch_d;    // channel addressed this frame
  logic [2:0]        tag_ch_q, tag_ch_d;    // channel whose result this frame returns
  logic [2:0]        ptr_q, ptr_d;
  logic              prime_q, prime_d;      // next frame is a priming frame
  logic              fprime_q, fprime_d;    // current frame is a priming frame
  logic              cont_q, cont_d;
  logic [3:0]        left_q, left_d;        // single scan: results still to report
  logic [DATA_W-1:0] data_q, data_d;
  logic [2:0]        sch_q, sch_d;
  logic              valid_q, valid_d;

  logic [2:0] next_ch;
  logic [2:0] ptr_after;
  logic [3:0] mask_cnt;
  logic       enter_setup;

  assign next_ch   = next_enabled(ch_mask, ptr_q);
  assign ptr_after = (next_ch == LAST_CH) ? 3'd0 : next_ch + 3'd1;
  assign mask_cnt  = count_ones(ch_mask);

  // Frame sequencing, SPI bit timing, capture and channel round-robin.
  always_comb begin
    // NOTE: every _d starts from its current value so no path through this
    // block leaves a signal unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    sclk_d      = sclk_q;
    cs_n_d      = cs_n_q;
    cmd_d       = cmd_q;
    rx_d        = rx_q;
    cur_ch_d    = cur_ch_q;
    tag_ch_d    = tag_ch_q;
    ptr_d       = ptr_q;
    prime_d     = prime_q;
    fprime_d    = fprime_q;
    cont_d      = cont_q;
    left_d      = left_q;
    data_d      = data_q;
    sch_d       = sch_q;
    valid_d     = 1'b0;
    enter_setup = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (enable && (|ch_mask) && (cont || start)) begin
          enter_setup = 1'b1;
          left_d      = mask_cnt;
        end
      end
      S_SETUP: begin
        if (cnt_q == HALF_LAST) begin
          state_d = S_SHIFT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_SHIFT: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          if (!sclk_q) begin
            // Rising edge: capture only the leading DATA_W result bits.
            sclk_d = 1'b1;
            if ({1'b0, bit_q} < DATA_BITS) rx_d = (rx_q << 1) | DATA_W'(ADC_DOUT);
          end else begin
            // Falling edge: present the next command bit.
            sclk_d = 1'b0;
            cmd_d  = {cmd_q[14:0], 1'b0};
            bit_d  = bit_q + 4'd1;
            if (bit_q == 4'd15) begin
              state_d = S_GAP;
              cs_n_d  = 1'b1;
              bit_d   = '0;
              if (!fprime_q) begin
                valid_d = 1'b1;
                data_d  = rx_q;
                sch_d   = tag_ch_q;
                if (left_q != 4'd0) left_d = left_q - 4'd1;
              end
            end
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d = '0;
          if (!enable || (ch_mask == '0) || (!cont_q && (left_q == 4'd0))) begin
            state_d = S_IDLE;
            prime_d = 1'b1;
            ptr_d   = '0;
          end else begin
            enter_setup = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Frame start: latch mode, pick the channel and load its command word.
    if (enter_setup) begin
      state_d  = S_SETUP;
      cnt_d    = '0;
      bit_d    = '0;
      cs_n_d   = 1'b0;
      sclk_d   = 1'b0;
      cmd_d    = {1'b1, next_ch, 1'b1, 11'b0};
      tag_ch_d = cur_ch_q;
      cur_ch_d = next_ch;
      ptr_d    = ptr_after;
      fprime_d = prime_q;
      prime_d  = 1'b0;
      cont_d   = cont;
    end
  end

  // State registers; reset drops the partial frame and parks the SPI lines.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      sclk_q   <= 1'b0;
      cs_n_q   <= 1'b1;
      cmd_q    <= '0;
      rx_q     <= '0;
      cur_ch_q <= '0;
      tag_ch_q <= '0;
      ptr_q    <= '0;
      prime_q  <= 1'b1;
      fprime_q <= 1'b1;
      cont_q   <= 1'b0;
      left_q   <= '0;
      data_q   <= '0;
      sch_q    <= '0;
      valid_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from the
      // values sampled at the same clock edge, independent of statement order.
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      sclk_q   <= sclk_d;
      cs_n_q   <= cs_n_d;
      cmd_q    <= cmd_d;
      rx_q     <= rx_d;
      cur_ch_q <= cur_ch_d;
      tag_ch_q <= tag_ch_d;
      ptr_q    <= ptr_d;
      prime_q  <= prime_d;
      fprime_q <= fprime_d;
      cont_q   <= cont_d;
      left_q   <= left_d;
      data_q   <= data_d;
      sch_q    <= sch_d;
      valid_q  <= valid_d;
    end
  end

  assign ADC_CS_N     = cs_n_q;
  assign ADC_SCLK     = sclk_q;
  assign ADC_DIN      = cmd_q[15];
  assign sample_data  = data_q;
  assign sample_ch    = sch_q;
  assign sample_valid = valid_q;
  assign busy         = (state_q != S_IDLE);

endmodule
